gray_code_counter: RTL and testbench



---
 rtl/gray_code_counter.sv | 85 ++++++++
 tb/tb_gray_code_counter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_code_counter.sv
// Parametrised up/down Gray-code counter with parallel load, wrap/saturate and terminal count.
// Define GRAY_BIN_OUT_EN to add the registered binary-index output Bin.
module gray_code_counter #(
    parameter int WIDTH    = 3,
    parameter int SATURATE = 0,
    parameter int RST_VAL  = 0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
`ifdef GRAY_BIN_OUT_EN
    output logic [WIDTH-1:0] Bin,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             Tc
);
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [WIDTH-1:0] MAX_BIN  = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] TOP_GRAY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_bin_step;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_at_end;

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Stepping is done on the recovered binary index, then re-encoded.
    always_comb begin
        w_bin       = gray_to_bin(r_q);
        w_at_end    = Up ? (w_bin == MAX_BIN) : (w_bin == '0);
        w_bin_step  = Up ? (w_bin + ONE) : (w_bin - ONE);
        w_bin_next  = ((SATURATE != 0) && w_at_end) ? w_bin : w_bin_step;
        w_gray_next = w_bin_next ^ (w_bin_next >> 1);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_q <= RST_GRAY;
        end else if (Load) begin
            r_q <= LoadVal;
        end else if (En) begin
            r_q <= w_gray_next;
        end
    end

`ifdef GRAY_BIN_OUT_EN
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] w_load_bin;

    always_comb begin
        w_load_bin = gray_to_bin(LoadVal);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_bin <= RST_BIN;
        end else if (Load) begin
            r_bin <= w_load_bin;
        end else if (En) begin
            r_bin <= w_bin_next;
        end
    end

    assign Bin = r_bin;
`endif

    assign Q  = r_q;
    assign Tc = Up ? (r_q == TOP_GRAY) : (r_q == '0);

endmodule

// File: tb/tb_gray_code_counter.sv
// Scoreboard bench for gray_code_counter: directed 3-bit wrap/saturate vectors plus an 8-bit model run.
// Bin checks are compiled in when GRAY_BIN_OUT_EN is defined.
module tb_gray_code_counter;
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rst3 = 1'b0, En3 = 1'b0, Up3 = 1'b1, Load3 = 1'b0;
    logic [2:0] LV3 = '0;
    logic [2:0] q0, q1;
    logic       tc0, tc1;
    logic       Rst8 = 1'b0, En8 = 1'b0, Up8 = 1'b1, Load8 = 1'b0;
    logic [7:0] LV8 = '0;
    logic [7:0] q2;
    logic       tc2;
`ifdef GRAY_BIN_OUT_EN
    logic [2:0] bin0, bin1;
    logic [7:0] bin2;
`endif

    gray_code_counter #(.WIDTH(3), .SATURATE(0), .RST_VAL(0)) u_wrap (
        .Clk(Clk), .Rst(Rst3), .En(En3), .Up(Up3), .Load(Load3), .LoadVal(LV3),
`ifdef GRAY_BIN_OUT_EN
        .Bin(bin0),
`endif
        .Q(q0), .Tc(tc0));

    gray_code_counter #(.WIDTH(3), .SATURATE(1), .RST_VAL(0)) u_sat (
        .Clk(Clk), .Rst(Rst3), .En(En3), .Up(Up3), .Load(Load3), .LoadVal(LV3),
`ifdef GRAY_BIN_OUT_EN
        .Bin(bin1),
`endif
        .Q(q1), .Tc(tc1));

    gray_code_counter #(.WIDTH(8), .SATURATE(0), .RST_VAL(0)) u_w8 (
        .Clk(Clk), .Rst(Rst8), .En(En8), .Up(Up8), .Load(Load8), .LoadVal(LV8),
`ifdef GRAY_BIN_OUT_EN
        .Bin(bin2),
`endif
        .Q(q2), .Tc(tc2));

    typedef struct {
        int         cyc;
        int         dut;
        logic [7:0] q;
        logic       tc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    function automatic logic [7:0] g2b8(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic check(input string name, input int dut, input logic [7:0] eq, input logic etc);
        logic [7:0] aq;
        logic       atc;
`ifdef GRAY_BIN_OUT_EN
        logic [7:0] abin;
`endif
        case (dut)
            0:       begin aq = {5'b0, q0}; atc = tc0; end
            1:       begin aq = {5'b0, q1}; atc = tc1; end
            default: begin aq = q2;         atc = tc2; end
        endcase
        n_cmp++;
        if (aq !== eq || atc !== etc) begin
            n_err++;
            $display("FAIL %s dut%0d: got Q=%b Tc=%b, expected Q=%b Tc=%b", name, dut, aq, atc, eq, etc);
        end
`ifdef GRAY_BIN_OUT_EN
        case (dut)
            0:       abin = {5'b0, bin0};
            1:       abin = {5'b0, bin1};
            default: abin = bin2;
        endcase
        n_cmp++;
        if (abin !== g2b8(eq)) begin
            n_err++;
            $display("FAIL %s_bin dut%0d: got Bin=%b, expected Bin=%b", name, dut, abin, g2b8(eq));
        end
`endif
    endtask

    task automatic push(input string name, input int dut, input logic [7:0] q, input logic tc);
        exp_t e;
        e.cyc = cyc + 1; e.dut = dut; e.q = q; e.tc = tc; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compares every expectation due on the edge just taken.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check(e.name, e.dut, e.q, e.tc);
            end
        end
    end

    task automatic step3(input string name, input logic rst, input logic en, input logic up,
                         input logic ld, input logic [2:0] lv,
                         input logic [2:0] e0q, input logic e0tc,
                         input logic [2:0] e1q, input logic e1tc);
        @(negedge Clk);
        Rst3 = rst; En3 = en; Up3 = up; Load3 = ld; LV3 = lv;
        push(name, 0, {5'b0, e0q}, e0tc);
        push(name, 1, {5'b0, e1q}, e1tc);
    endtask

    initial begin
        logic [7:0] idx;
        logic [7:0] eg;
        logic       ld, en, up;
        logic [7:0] lv;

        #2;
        Rst3 = 1'b1; Rst8 = 1'b1;
        #1;
        check("rst_q", 0, 8'b000, 1'b0);
        check("rst_q", 1, 8'b000, 1'b0);
        check("rst_q", 2, 8'h00, 1'b0);
        Up3 = 1'b0;
        #1;
        check("rst_tc_dn", 0, 8'b000, 1'b1);
        check("rst_tc_dn", 1, 8'b000, 1'b1);
        Up3 = 1'b1;
        @(negedge Clk);
        Rst3 = 1'b0; Rst8 = 1'b0;

        //       name         rst  en   up   ld   lv      wrap          saturate
        step3("up1",       0, 1, 1, 0, 3'b000, 3'b001, 0, 3'b001, 0);
        step3("up2",       0, 1, 1, 0, 3'b000, 3'b011, 0, 3'b011, 0);
        step3("up3",       0, 1, 1, 0, 3'b000, 3'b010, 0, 3'b010, 0);
        step3("up4",       0, 1, 1, 0, 3'b000, 3'b110, 0, 3'b110, 0);
        step3("up5",       0, 1, 1, 0, 3'b000, 3'b111, 0, 3'b111, 0);
        step3("up6",       0, 1, 1, 0, 3'b000, 3'b101, 0, 3'b101, 0);
        step3("up7",       0, 1, 1, 0, 3'b000, 3'b100, 1, 3'b100, 1);
        step3("up8_end",   0, 1, 1, 0, 3'b000, 3'b000, 0, 3'b100, 1);
        step3("hold_dn",   0, 0, 0, 0, 3'b000, 3'b000, 1, 3'b100, 0);
        step3("dn1",       0, 1, 0, 0, 3'b000, 3'b100, 0, 3'b101, 0);
        step3("dn2",       0, 1, 0, 0, 3'b000, 3'b101, 0, 3'b111, 0);
        step3("load0",     0, 1, 0, 1, 3'b000, 3'b000, 1, 3'b000, 1);
        step3("dn_end",    0, 1, 0, 0, 3'b000, 3'b100, 0, 3'b000, 1);
        step3("up_wrap",   0, 1, 1, 0, 3'b000, 3'b000, 0, 3'b001, 0);
        step3("load110",   0, 1, 1, 1, 3'b110, 3'b110, 0, 3'b110, 0);
        step3("after_ld",  0, 1, 1, 0, 3'b000, 3'b111, 0, 3'b111, 0);
        step3("load_same", 0, 0, 1, 1, 3'b111, 3'b111, 0, 3'b111, 0);
        step3("dir_dn",    0, 1, 0, 0, 3'b000, 3'b110, 0, 3'b110, 0);
        step3("dir_up",    0, 1, 1, 0, 3'b000, 3'b111, 0, 3'b111, 0);
        step3("load_top",  0, 1, 1, 1, 3'b100, 3'b100, 1, 3'b100, 1);
        step3("sat_up_a",  0, 1, 1, 0, 3'b000, 3'b000, 0, 3'b100, 1);
        step3("load011",   0, 0, 1, 1, 3'b011, 3'b011, 0, 3'b011, 0);

        // Reset raised between edges must act before the next Clk edge.
        @(posedge Clk);
        #3;
        Rst3 = 1'b1;
        #1;
        check("rst_async", 0, 8'b000, 1'b0);
        check("rst_async", 1, 8'b000, 1'b0);
        step3("rst_hold",  1, 1, 1, 0, 3'b000, 3'b000, 0, 3'b000, 0);
        step3("resume",    0, 1, 1, 0, 3'b000, 3'b001, 0, 3'b001, 0);
        step3("idle",      0, 0, 1, 0, 3'b000, 3'b001, 0, 3'b001, 0);

        // 8-bit run against an index model; first two vectors force the top-of-range wrap.
        idx = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            @(negedge Clk);
            if (i == 0) begin
                ld = 1'b1; en = 1'b0; up = 1'b1; lv = 8'h80;
            end else if (i == 1) begin
                ld = 1'b0; en = 1'b1; up = 1'b1; lv = 8'h00;
            end else begin
                ld = ($urandom_range(0, 15) == 0);
                en = ($urandom_range(0, 3) != 0);
                up = 1'($urandom_range(0, 1));
                lv = 8'($urandom_range(0, 255));
            end
            En8 = en; Up8 = up; Load8 = ld; LV8 = lv;
            if (ld)      idx = g2b8(lv);
            else if (en) idx = up ? idx + 8'd1 : idx - 8'd1;
            eg = idx ^ (idx >> 1);
            push("w8_model", 2, eg, up ? (eg == 8'h80) : (eg == 8'h00));
        end
        @(negedge Clk);
        En8 = 1'b0; Load8 = 1'b0;

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge Clk);
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
